// File: rtl/nibble_inc_sequencer.sv
// nibble_inc_sequencer: increments a WIDTH-bit register by one over several
// cycles. A single shared 4-bit incrementor handles one nibble per clock,
// starting at the least significant nibble. The carry ripples from one cycle
// to the next. The block has a start/busy/done handshake and a parallel load
// port.
// Optional build macro: NIBBLE_INC_EARLY_EXIT_EN. When it is defined, the walk
// stops after the first nibble that produces no carry.
module nibble_inc_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic               c;
    logic [IDX_W+1:0]   nib_base;
    logic [3:0]         nib_cur;
    logic [3:0]         nib_inc;
    logic               cout;
    logic               last_nib;

    // Shared 4-bit incrementor: returns {carry_out, sum}.
    function automatic logic [4:0] inc4(input logic [3:0] a);
        return {1'b0, a} + 5'd1;
    endfunction

    assign nib_base          = {idx, 2'b00};
    assign nib_cur           = value[nib_base +: 4];
    assign {cout, nib_inc}   = inc4(nib_cur);
    assign last_nib          = (idx == IDX_W'(N - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: run the nibble walk, then spend a single DONE cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !load) state_nxt = RUN;
            RUN: begin
                if (last_nib) begin
                    state_nxt = DONE;
                end
`ifdef NIBBLE_INC_EARLY_EXIT_EN
                // Without a carry, none of the upper nibbles change.
                else if (c && !cout) begin
                    state_nxt = DONE;
                end
`else
                else begin
                    state_nxt = RUN;
                end
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load/start capture in IDLE, one nibble per RUN cycle, ovf on exit
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            idx   <= '0;
            c     <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        value <= load_val;
                    end else if (start) begin
                        idx <= '0;
                        c   <= 1'b1;
                    end
                end
                RUN: begin
                    if (c) begin
                        value[nib_base +: 4] <= nib_inc;
                        c                    <= cout;
                    end
                    idx <= idx + 1'b1;
                    // When the walk exits, ovf takes the carry left after the final nibble.
                    if (state_nxt == DONE) begin
                        ovf <= c & cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_inc_sequencer.sv
// Directed testbench for nibble_inc_sequencer (WIDTH=16).
module tb_nibble_inc_sequencer;

    localparam int WIDTH = 16;

`ifdef NIBBLE_INC_EARLY_EXIT_EN
    localparam int R_1234 = 1;
    localparam int R_00FF = 3;
    localparam int R_SMALL = 1;
`else
    localparam int R_1234 = 4;
    localparam int R_00FF = 4;
    localparam int R_SMALL = 4;
`endif
    localparam int R_FFFF = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    nibble_inc_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load     (load),
        .load_val (load_val),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count RUN cycles until done is observed; bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load_val = v;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        int pulses;
        int t;
        int d[3];

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);

        // 0x1234 + 1
        do_load(16'h1234);
        chk("load_1234", 32'(value), 32'h1234);
        chk("load_busy", 32'(busy), 32'h0);
        do_start();
        chk("busy_after_start", 32'(busy), 32'h1);
        wait_done(n);
        chk("lat_1234", 32'(n), 32'(R_1234));
        chk("res_1234", 32'(value), 32'h1235);
        chk("ovf_1234", 32'(ovf), 32'h0);
        tick();
        chk("done_pulse_1234", 32'(done), 32'h0);
        chk("busy_fall_1234", 32'(busy), 32'h0);

        // 0x00FF + 1 with a partial intermediate value
        do_load(16'h00FF);
        do_start();
        tick();
        chk("mid_00FF", 32'(value), 32'h00F0);
        wait_done(n);
        chk("lat_00FF", 32'(n + 1), 32'(R_00FF));
        chk("res_00FF", 32'(value), 32'h0100);
        chk("ovf_00FF", 32'(ovf), 32'h0);
        tick();

        // 0xFFFF + 1 wraps and sets ovf
        do_load(16'hFFFF);
        do_start();
        wait_done(n);
        chk("lat_FFFF", 32'(n), 32'(R_FFFF));
        chk("res_FFFF", 32'(value), 32'h0000);
        chk("ovf_FFFF", 32'(ovf), 32'h1);
        tick();
        chk("done_pulse_FFFF", 32'(done), 32'h0);
        tick();
        tick();
        chk("ovf_hold", 32'(ovf), 32'h1);

        // load has priority over start in IDLE
        load_val = 16'hA5A5;
        load     = 1'b1;
        start    = 1'b1;
        tick();
        load     = 1'b0;
        start    = 1'b0;
        chk("ld_st_value", 32'(value), 32'hA5A5);
        chk("ld_st_busy", 32'(busy), 32'h0);
        tick();
        chk("ld_st_busy2", 32'(busy), 32'h0);
        chk("ld_st_done", 32'(done), 32'h0);

        // start and load during RUN are ignored
        do_start();
        load_val = 16'h1111;
        load     = 1'b1;
        start    = 1'b1;
        wait_done(n);
        chk("ign_lat", 32'(n), 32'(R_1234));
        load     = 1'b0;
        start    = 1'b0;
        tick();
        chk("ign_value", 32'(value), 32'hA5A6);
        chk("ign_ovf", 32'(ovf), 32'h0);
        chk("ign_done", 32'(done), 32'h0);
        chk("ign_busy", 32'(busy), 32'h0);

        // reset mid-RUN discards the increment
        do_load(16'h0FFF);
        do_start();
        tick();
        tick();
        chk("abort_mid", 32'(value), 32'h0F00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_value", 32'(value), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_ovf", 32'(ovf), 32'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'h0);

        // start held high: three back-to-back increments from zero
        pulses = 0;
        t      = 0;
        start  = 1'b1;
        while (pulses < 3 && t < 60) begin
            tick();
            t++;
            if (done === 1'b1) begin
                d[pulses] = t;
                pulses++;
            end
        end
        start = 1'b0;
        chk("hold_pulses", 32'(pulses), 32'h3);
        tick();
        chk("hold_value", 32'(value), 32'h0003);
        chk("hold_first", 32'(d[0]), 32'(R_SMALL + 1));
        chk("hold_space1", 32'(d[1] - d[0]), 32'(R_SMALL + 2));
        chk("hold_space2", 32'(d[2] - d[1]), 32'(R_SMALL + 2));
        chk("hold_idle", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
